// File: rtl/apb_slave_fsm.sv
// APB slave front-end that turns APB transfers into one-cycle
// write/read strobes towards a register bank.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   PSEL, PENABLE     APB select and access-phase indicator
//   PWRITE            APB direction (1 write, 0 read)
//   PADDR, PWDATA     APB word address and write data
//   PRDATA            registered APB read data
//   PREADY, PSLVERR   transfer completion and error response
//   write_en, rd_en   one-cycle bank write strobe / read request
//   addr, data_in     captured bank address and write data
//   rd_data           bank read data, valid one cycle after rd_en
//   busy              watermark engine running (CTRL start active)
module apb_slave_fsm #(
    parameter int Amba_Word       = 16,
    parameter int Amba_Addr_Depth = 20,
    parameter int Bank_Size       = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [Amba_Addr_Depth:0] PADDR,
    input  logic [Amba_Word-1:0]     PWDATA,
    output logic [Amba_Word-1:0]     PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic                     write_en,
    output logic                     rd_en,
    output logic [Amba_Addr_Depth:0] addr,
    output logic [Amba_Word-1:0]     data_in,
    input  logic [Amba_Word-1:0]     rd_data,
    input  logic                     busy
);

    localparam int AW = Amba_Addr_Depth + 1;
    localparam logic [AW-1:0] LIMIT = AW'(Bank_Size);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [AW-1:0]        r_addr;
    logic [Amba_Word-1:0] r_data;
    logic                 r_err;
    logic [Amba_Word-1:0] r_prdata;

    logic w_setup;
    logic w_capture;
    logic w_err_addr;
    logic w_err_busy;
    logic w_err;

    // A setup phase is only recognised while idle; PENABLE alone
    // without a preceding setup is ignored.
    assign w_setup   = PSEL & ~PENABLE;
    assign w_capture = (r_state == IDLE) & w_setup;

    // Address 0 (CTRL) stays writable while busy so software can
    // always stop the engine.
    assign w_err_addr = (PADDR >= LIMIT);
    assign w_err_busy = PWRITE & busy & (PADDR != '0);
    assign w_err      = w_err_addr | w_err_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_setup) begin
                    if (w_err) begin
                        w_next = RESP;
                    end else if (PWRITE) begin
                        w_next = WR;
                    end else begin
                        w_next = RD_REQ;
                    end
                end
            end
            WR:      w_next = RESP;
            RD_REQ:  w_next = RD_WAIT;
            RD_WAIT: w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transfer attributes are frozen at capture, so later busy or
    // bus changes cannot disturb the transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_capture) begin
            r_addr <= PADDR;
            r_data <= PWDATA;
            r_err  <= w_err;
        end
    end

    // Read data is only touched by reads: a good read loads the
    // bank value, an errored read returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata <= '0;
        end else if (r_state == RD_WAIT) begin
            r_prdata <= rd_data;
        end else if (w_capture & w_err & ~PWRITE) begin
            r_prdata <= '0;
        end
    end

    always_comb begin
        write_en = (r_state == WR);
        rd_en    = (r_state == RD_REQ);
        PREADY   = (r_state == RESP);
        PSLVERR  = (r_state == RESP) & r_err;
        addr     = r_addr;
        data_in  = r_data;
        PRDATA   = r_prdata;
    end

endmodule

// File: tb/tb_apb_slave_fsm.sv
// Directed bench for apb_slave_fsm with a bank model and a
// scoreboard of expected APB responses.
module tb_apb_slave_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [20:0] PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        write_en;
    logic        rd_en;
    logic [20:0] addr;
    logic [15:0] data_in;
    logic [15:0] rd_data;
    logic        busy;

    apb_slave_fsm dut (
        .clk     (clk),
        .rst     (rst),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .write_en(write_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .data_in (data_in),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        err;
        logic [20:0] a;
        logic [15:0] d;
        logic [15:0] prdata;
        int          lat;
        int          we;
        int          re;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] bank[64];
    logic [15:0] model[64];
    logic [15:0] exp_prdata;
    logic        bank_clr;
    int          n_we = 0;
    int          n_re = 0;
    int          n_rdy = 0;
    int          n_ovl = 0;
    logic [20:0] mon_a = '0;
    logic [15:0] mon_d = '0;

    // Register bank: read data valid one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 64; i++) bank[i] <= '0;
        end else if (write_en) begin
            bank[addr[5:0]] <= data_in;
        end
        rd_data <= rd_en ? bank[addr[5:0]] : 16'hBAD0;
    end

    always @(negedge clk) begin
        if (write_en) begin
            n_we  = n_we + 1;
            mon_a = addr;
            mon_d = data_in;
        end
        if (rd_en) n_re = n_re + 1;
        if (PREADY) n_rdy = n_rdy + 1;
        if (write_en && rd_en) n_ovl = n_ovl + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [20:0] a,
                        input logic [15:0] d, input logic flip_busy);
        exp_t e;
        int   cyc;
        int   b_we;
        int   b_re;
        e.wr  = wr;
        e.a   = a;
        e.d   = d;
        e.err = (a >= 21'd42) || (wr && busy && a != 21'd0);
        if (!e.err && wr) model[a[5:0]] = d;
        if (!wr) exp_prdata = e.err ? 16'h0 : model[a[5:0]];
        e.prdata = exp_prdata;
        e.lat    = e.err ? 1 : (wr ? 2 : 3);
        e.we     = (!e.err && wr) ? 1 : 0;
        e.re     = (!e.err && !wr) ? 1 : 0;
        @(negedge clk);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        q.push_back(e);
        b_we = n_we;
        b_re = n_re;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        if (flip_busy) busy = ~busy;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!PREADY && cyc < 8);
        e = q.pop_front();
        check("latency", cyc, e.lat);
        check("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
        check("prdata", {16'd0, PRDATA}, {16'd0, e.prdata});
        check("we_pulses", n_we - b_we, e.we);
        check("re_pulses", n_re - b_re, e.re);
        if (e.we == 1) begin
            check("wr_addr", {11'd0, mon_a}, {11'd0, e.a});
            check("wr_data", {16'd0, mon_d}, {16'd0, e.d});
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge clk);
        check("pready_drop", {31'd0, PREADY}, 32'd0);
    endtask

    initial begin
        int          b_we;
        int          b_re;
        int          b_rdy;
        logic [20:0] ra;
        logic [15:0] rd;

        rst        = 1'b1;
        bank_clr   = 1'b1;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;
        busy       = 1'b0;
        exp_prdata = '0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", {16'd0, PRDATA}, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_addr", {11'd0, addr}, 32'd0);
        check("rst_data_in", {16'd0, data_in}, 32'd0);
        rst      = 1'b0;
        bank_clr = 1'b0;

        xfer(1'b1, 21'h05, 16'h0040, 1'b0);
        xfer(1'b1, 21'h01, 16'h00FF, 1'b0);
        xfer(1'b0, 21'h01, 16'h0000, 1'b0);
        xfer(1'b0, 21'd42, 16'h0000, 1'b0);
        xfer(1'b0, 21'h01, 16'h0000, 1'b0);
        xfer(1'b1, 21'h03, 16'h5A5A, 1'b0);
        xfer(1'b1, 21'h1FFFFF, 16'h7777, 1'b0);
        xfer(1'b0, 21'd41, 16'h0000, 1'b0);

        // PENABLE without a setup phase must be ignored.
        @(negedge clk);
        b_we    = n_we;
        b_re    = n_re;
        b_rdy   = n_rdy;
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 21'h07;
        PWDATA  = 16'h9999;
        repeat (4) @(negedge clk);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check("noset_we", n_we - b_we, 0);
        check("noset_re", n_re - b_re, 0);
        check("noset_rdy", n_rdy - b_rdy, 0);

        busy = 1'b1;
        xfer(1'b1, 21'h0A, 16'h1111, 1'b0);
        xfer(1'b1, 21'h00, 16'h0000, 1'b0);
        xfer(1'b0, 21'h05, 16'h0000, 1'b0);
        busy = 1'b0;
        xfer(1'b1, 21'h0B, 16'h1234, 1'b1);
        xfer(1'b0, 21'h0B, 16'h0000, 1'b1);
        xfer(1'b1, 21'h02, 16'hBEEF, 1'b0);
        xfer(1'b0, 21'h01, 16'h0000, 1'b0);

        // Reset while waiting for bank read data aborts the read.
        @(negedge clk);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 21'h02;
        b_rdy   = n_rdy;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        exp_prdata = '0;
        check("abort_pready", {31'd0, PREADY}, 32'd0);
        check("abort_prdata", {16'd0, PRDATA}, 32'd0);
        check("abort_rd_en", {31'd0, rd_en}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_resp", n_rdy - b_rdy, 0);
        xfer(1'b0, 21'h02, 16'h0000, 1'b0);

        for (int i = 0; i < 5; i++) begin
            ra = 21'($urandom_range(0, 41));
            rd = 16'($urandom);
            xfer(1'b1, ra, rd, 1'b0);
            xfer(1'b0, ra, 16'h0000, 1'b0);
        end

        check("we_rd_overlap", n_ovl, 0);
        check("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
